ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares one AHB slave segment (HCLK/HRESETn domain) between up to NUM_MASTERS masters.
- Issues one-hot HGRANT, drives HMASTER (the select for the address/control and write-data muxes) and HMASTLOCK.
- Tracks fixed-length bursts and locked sequences from the muxed HTRANS/HBURST so that ownership never changes mid-burst or mid-lock.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- MW, 2, width of HMASTER; must satisfy 2**MW >= NUM_MASTERS.
- DEFAULT_MASTER, 0, master granted when nobody requests, and after reset.

Ports:
- HCLK  input  1  bus clock, all logic on rising edge.
- HRESETn  input  1  reset, synchronous, active-low.
- HBUSREQ  input  NUM_MASTERS  bus request, bit i = master i.
- HLOCK  input  NUM_MASTERS  locked-access request, bit i = master i.
- HTRANS  input  2  muxed transfer type of current HMASTER (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  input  3  muxed burst type of current HMASTER.
- HREADY  input  1  bus-wide ready; registers advance only when high.
- HGRANT  output  NUM_MASTERS  one-hot grant.
- HMASTER  output  MW  index of the master owning the current address phase.
- HMASTLOCK  output  1  current address phase is part of a locked sequence.

Behaviour:
- Reset (HRESETn=0 at an edge):
  - HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0.
  - State ARB, beat counter=0, round-robin pointer=DEFAULT_MASTER.
  - Applies mid-burst or mid-lock too, with no completion of the sequence.
- HGRANT is always exactly one-hot; it is never all-zero.
- Registers hold when HREADY=0, except HGRANT, which may update only in state ARB.
- States:
  - ARB: free to re-arbitrate every cycle.
  - BURST: fixed-length burst in progress.
  - LOCK: granted master holds HLOCK.
  - LTAIL: one extra cycle after lock release.
- Arbitration, when allowed:
  - Search HBUSREQ round-robin starting at (pointer+1) mod NUM_MASTERS, wrapping; the first requester wins.
  - If only the current owner requests, it keeps the grant.
  - If none request, grant DEFAULT_MASTER.
  - The pointer updates to the winner whenever the grant changes.
  - Latency: request sampled at edge t gives HGRANT at edge t+1.
- HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)] at each edge with HREADY=1.
- Burst counting, at HREADY=1 edges only:
  - HTRANS=NONSEQ with HBURST INCR4/WRAP4 (011/010): counter=3, go to BURST.
  - HTRANS=NONSEQ with INCR8/WRAP8 (101/100): counter=7, go to BURST.
  - HTRANS=NONSEQ with INCR16/WRAP16 (111/110): counter=15, go to BURST.
  - SINGLE (000) and INCR (001) do not enter BURST.
  - SEQ decrements the counter; BUSY holds it.
  - IDLE, or a NONSEQ during BURST (early termination), clears the counter; a NONSEQ then reloads per its HBURST.
- Re-arbitration is allowed in ARB, and in BURST when counter==1 and HTRANS==SEQ (last-beat address phase). This gives the new master its grant for the cycle after the burst.
- When the counter reaches 0, BURST returns to ARB (or LOCK if HLOCK of the owner is set).
- Lock:
  - In any state, if HLOCK[owner]=1 at an HREADY edge, enter LOCK.
  - Grant is frozen while in LOCK; bursts inside LOCK are counted but do not change the state.
  - HLOCK[owner] falling moves LOCK to LTAIL; grant is held one more HREADY cycle, then ARB.
- Simultaneous events:
  - Burst end together with lock assert: LOCK wins.
  - A requester dropping HBUSREQ while granted in ARB loses the grant at the next arbitration.
- Counter width is 4 bits; no wrap occurs because the load is at most 15.

Test Plan:
- Reset, no requests -> HGRANT=0001, HMASTER=0, HMASTLOCK=0; after reset pulse, assert HRESETn low mid-INCR8 -> same values next edge, state ARB.
- HBUSREQ=0110 held, SINGLE transfers, HREADY=1 -> grants alternate 0010, 0100, 0010, ...; HMASTER lags HGRANT by one cycle.
- Master 1 NONSEQ INCR4 then SEQ×3 while master 2 requests -> HGRANT stays 0010 until the 3rd SEQ edge, then 0100; HMASTER=2 on the cycle after the last beat.
- Same INCR4 with HREADY=0 for 2 cycles plus one BUSY mid-burst -> grant change delayed by exactly 3 cycles.
- Master 3 with HLOCK=1, HBUSREQ=1111 -> HGRANT=1000 and HMASTLOCK=1 throughout; after HLOCK drops, grant held one more cycle, then 0001.
- Early termination: INCR16 then IDLE after 2 beats with master 0 requesting -> grant moves to master 0 on the next edge.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: one-hot grant, HMASTER/HMASTLOCK pipelining, and
// burst/lock tracking so that ownership is never handed over mid-sequence.
//
// state | meaning
// ARB   | free to re-arbitrate every cycle
// BURST | fixed-length burst in progress, handover only on last-beat address
// LOCK  | granted master holds HLOCK, grant frozen
// LTAIL | one extra cycle after lock release, grant still frozen
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2,
    LTAIL = 2'd3
  } state_e;

  localparam logic [1:0]    T_IDLE   = 2'b00;
  localparam logic [1:0]    T_NONSEQ = 2'b10;
  localparam logic [1:0]    T_SEQ    = 2'b11;
  localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [MW-1:0] owner_q, owner_d;
  logic [MW-1:0] ptr_q, ptr_d;
  logic [MW-1:0] hmaster_q, hmaster_d;
  logic          mastlock_q, mastlock_d;

  logic [MW-1:0] rr_winner;
  logic          owner_lock;
  logic          last_beat;
  logic          arb_en;

  assign owner_lock = HLOCK[owner_q];
  assign last_beat  = (state_q == BURST) && (cnt_q == 4'd1) &&
                      (HTRANS == T_SEQ) && HREADY;
  // A master asking for a lock keeps the grant until LOCK is entered.
  assign arb_en     = !owner_lock && ((state_q == ARB) || last_beat);

  // Descending scan so the requester closest after the pointer is kept last.
  always_comb begin : rr_search
    int idx;
    idx       = 0;
    rr_winner = DEF_IDX;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (HBUSREQ[MW'(idx)]) rr_winner = MW'(idx);
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hmaster_d  = hmaster_q;
    mastlock_d = mastlock_q;

    if (arb_en) begin
      owner_d = rr_winner;
      if (rr_winner != owner_q) ptr_d = rr_winner;
    end

    if (HREADY) begin
      hmaster_d  = owner_q;
      mastlock_d = owner_lock;

      case (HTRANS)
        T_NONSEQ: begin
          case (HBURST)
            3'b010, 3'b011: cnt_d = 4'd3;
            3'b100, 3'b101: cnt_d = 4'd7;
            3'b110, 3'b111: cnt_d = 4'd15;
            default:        cnt_d = 4'd0;
          endcase
        end
        T_SEQ:   if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        T_IDLE:  cnt_d = 4'd0;
        default: cnt_d = cnt_q;
      endcase

      if (owner_lock) begin
        state_d = LOCK;
      end else begin
        case (state_q)
          LOCK:    state_d = LTAIL;
          BURST:   state_d = (cnt_d == 4'd0) ? ARB : BURST;
          default: state_d = (cnt_d != 4'd0) ? BURST : ARB;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ARB;
      cnt_q      <= 4'd0;
      owner_q    <= DEF_IDX;
      ptr_q      <= DEF_IDX;
      hmaster_q  <= DEF_IDX;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hmaster_q  <= hmaster_d;
      mastlock_q <= mastlock_d;
    end
  end

  always_comb begin : grant_decode
    HGRANT          = '0;
    HGRANT[owner_q] = 1'b1;
  end

  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios with fixed expectations, then
// randomized traffic compared against a transaction-level reference model.
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int MW  = 2;
  localparam int DEF = 0;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam int MD_ARB   = 0;
  localparam int MD_BURST = 1;
  localparam int MD_LOCK  = 2;
  localparam int MD_TAIL  = 3;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [N-1:0]  HBUSREQ;
  logic [N-1:0]  HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [N-1:0]  HGRANT;
  logic [MW-1:0] HMASTER;
  logic          HMASTLOCK;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_own, m_ptr, m_hm, m_ml, m_mode, m_beats;

  ahb_arbiter #(.NUM_MASTERS(N), .MW(MW), .DEFAULT_MASTER(DEF)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HBURST   (HBURST),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  function automatic int burst_len(logic [2:0] b);
    if (b == 3'b010 || b == 3'b011) return 4;
    if (b == 3'b100 || b == 3'b101) return 8;
    if (b == 3'b110 || b == 3'b111) return 16;
    return 1;
  endfunction

  function automatic int rr_pick(logic [N-1:0] req, int last);
    logic [MW-1:0] ix;
    for (int k = 1; k <= N; k++) begin
      ix = MW'((last + k) % N);
      if (req[ix]) return (last + k) % N;
    end
    return DEF;
  endfunction

  task automatic model_step();
    int  nxt;
    int  owner;
    int  nb;
    bit  olock;
    bit  may_arb;
    if (!HRESETn) begin
      m_own = DEF; m_ptr = DEF; m_hm = DEF; m_ml = 0;
      m_mode = MD_ARB; m_beats = 0;
      return;
    end
    owner   = m_own;
    olock   = HLOCK[MW'(owner)];
    nxt     = owner;
    may_arb = !olock && (m_mode == MD_ARB ||
              (HREADY && m_mode == MD_BURST && m_beats == 1 && HTRANS == SEQ));
    if (may_arb) nxt = rr_pick(HBUSREQ, m_ptr);
    if (HREADY) begin
      m_hm = owner;
      m_ml = int'(olock);
      case (HTRANS)
        NONSEQ:  nb = burst_len(HBURST) - 1;
        IDLE:    nb = 0;
        SEQ:     nb = (m_beats > 0) ? m_beats - 1 : 0;
        default: nb = m_beats;
      endcase
      if (olock)                    m_mode = MD_LOCK;
      else if (m_mode == MD_LOCK)   m_mode = MD_TAIL;
      else if (m_mode == MD_BURST)  m_mode = (nb == 0) ? MD_ARB : MD_BURST;
      else                          m_mode = (nb > 0) ? MD_BURST : MD_ARB;
      m_beats = nb;
    end
    if (nxt != owner) m_ptr = nxt;
    m_own = nxt;
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = IDLE;
    HBURST  = 3'b000;
    HREADY  = 1'b1;
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++; $display("FAIL reset_grant: got %b expected 0001", HGRANT);
    end
    checks++;
    if (HMASTER !== 2'd0) begin
      failures++; $display("FAIL reset_hmaster: got %0d expected 0", HMASTER);
    end
    checks++;
    if (HMASTLOCK !== 1'b0) begin
      failures++; $display("FAIL reset_mastlock: got %b expected 0", HMASTLOCK);
    end
    // reset in the middle of an INCR8
    HBUSREQ = 4'b0010; tick();
    HTRANS = NONSEQ; HBURST = 3'b101; tick();
    HTRANS = SEQ; tick(); tick();
    HRESETn = 1'b0; tick();
    checks++;
    if (HGRANT !== 4'b0001 || HMASTER !== 2'd0 || HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_burst: got grant=%b hmaster=%0d lock=%b expected 0001/0/0",
               HGRANT, HMASTER, HMASTLOCK);
    end
    HRESETn = 1'b1; HBUSREQ = 4'b0100; HTRANS = SEQ; tick();
    checks++;
    if (HGRANT !== 4'b0100) begin
      failures++; $display("FAIL reset_arb_state: got %b expected 0100", HGRANT);
    end
  endtask

  task automatic test_round_robin();
    int prev;
    logic [N-1:0] eg;
    do_reset();
    prev    = 0;
    HBUSREQ = 4'b0110;
    HTRANS  = NONSEQ;
    HBURST  = 3'b000;
    for (int k = 0; k < 6; k++) begin
      eg = (k % 2 == 0) ? 4'b0010 : 4'b0100;
      tick();
      checks++;
      if (HGRANT !== eg) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, HGRANT, eg);
      end
      checks++;
      if (int'(HMASTER) != prev) begin
        failures++; $display("FAIL rr_hmaster[%0d]: got %0d expected %0d", k, HMASTER, prev);
      end
      prev = (k % 2 == 0) ? 1 : 2;
    end
  endtask

  task automatic test_burst(input bit stall);
    logic [1:0]   tr [6];
    bit           rd [6];
    int           n;
    logic [N-1:0] eg;
    do_reset();
    HBUSREQ = 4'b0010; tick(); tick();
    HTRANS = NONSEQ; HBURST = 3'b011; tick();
    checks++;
    if (HGRANT !== 4'b0010) begin
      failures++; $display("FAIL burst_start: got %b expected 0010", HGRANT);
    end
    HBUSREQ = 4'b0110;
    if (stall) begin
      n  = 6;
      tr = '{SEQ, SEQ, SEQ, BUSY, SEQ, SEQ};
      rd = '{1, 0, 0, 1, 1, 1};
    end else begin
      n  = 3;
      tr = '{SEQ, SEQ, SEQ, IDLE, IDLE, IDLE};
      rd = '{1, 1, 1, 1, 1, 1};
    end
    for (int i = 0; i < n; i++) begin
      HTRANS = tr[i];
      HREADY = rd[i];
      tick();
      eg = (i == n - 1) ? 4'b0100 : 4'b0010;
      checks++;
      if (HGRANT !== eg) begin
        failures++;
        $display("FAIL burst_grant[stall=%0d,%0d]: got %b expected %b", stall, i, HGRANT, eg);
      end
      checks++;
      if (HMASTER !== 2'd1) begin
        failures++;
        $display("FAIL burst_hmaster[stall=%0d,%0d]: got %0d expected 1", stall, i, HMASTER);
      end
    end
    HTRANS = IDLE; HREADY = 1'b1; tick();
    checks++;
    if (HMASTER !== 2'd2) begin
      failures++; $display("FAIL burst_handover[stall=%0d]: got %0d expected 2", stall, HMASTER);
    end
  endtask

  task automatic test_lock();
    do_reset();
    HBUSREQ = 4'b1000; HLOCK = 4'b1000; tick();
    checks++;
    if (HGRANT !== 4'b1000) begin
      failures++; $display("FAIL lock_grant_first: got %b expected 1000", HGRANT);
    end
    tick();
    HBUSREQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      HTRANS = (i == 0) ? NONSEQ : SEQ;
      HBURST = 3'b011;
      tick();
      checks++;
      if (HGRANT !== 4'b1000 || HMASTLOCK !== 1'b1 || HMASTER !== 2'd3) begin
        failures++;
        $display("FAIL lock_hold[%0d]: got grant=%b lock=%b hmaster=%0d expected 1000/1/3",
                 i, HGRANT, HMASTLOCK, HMASTER);
      end
    end
    HTRANS = IDLE; HLOCK = 4'b0000; tick();
    checks++;
    if (HGRANT !== 4'b1000 || HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL lock_release: got grant=%b lock=%b expected 1000/0", HGRANT, HMASTLOCK);
    end
    tick();
    checks++;
    if (HGRANT !== 4'b1000) begin
      failures++; $display("FAIL lock_tail: got %b expected 1000", HGRANT);
    end
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++; $display("FAIL lock_after_tail: got %b expected 0001", HGRANT);
    end
  endtask

  task automatic test_early_term();
    do_reset();
    HBUSREQ = 4'b0010; tick(); tick();
    HTRANS = NONSEQ; HBURST = 3'b111; tick();
    HBUSREQ = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      HTRANS = (i < 2) ? SEQ : IDLE;
      tick();
      checks++;
      if (HGRANT !== 4'b0010) begin
        failures++; $display("FAIL early_hold[%0d]: got %b expected 0010", i, HGRANT);
      end
    end
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++; $display("FAIL early_handover: got %b expected 0001", HGRANT);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      HRESETn = ($urandom_range(0, 199) != 0);
      HBUSREQ = N'($urandom);
      HLOCK   = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) HLOCK[b] = 1'b1;
      HTRANS  = 2'($urandom);
      HBURST  = 3'($urandom);
      HREADY  = ($urandom_range(0, 4) != 0);
      tick();
      eg = '0;
      eg[MW'(m_own)] = 1'b1;
      checks++;
      if (HGRANT !== eg) begin
        failures++; $display("FAIL rand_grant[%0d]: got %b expected %b", c, HGRANT, eg);
      end
      checks++;
      if (!$onehot(HGRANT)) begin
        failures++; $display("FAIL rand_onehot[%0d]: got %b expected one-hot", c, HGRANT);
      end
      checks++;
      if (int'(HMASTER) != m_hm) begin
        failures++; $display("FAIL rand_hmaster[%0d]: got %0d expected %0d", c, HMASTER, m_hm);
      end
      checks++;
      if (int'(HMASTLOCK) != m_ml) begin
        failures++; $display("FAIL rand_mastlock[%0d]: got %b expected %0d", c, HMASTLOCK, m_ml);
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = IDLE;
    HBURST  = 3'b000;
    HREADY  = 1'b1;
    m_own = DEF; m_ptr = DEF; m_hm = DEF; m_ml = 0; m_mode = MD_ARB; m_beats = 0;
    test_reset();
    test_round_robin();
    test_burst(1'b0);
    test_burst(1'b1);
    test_lock();
    test_early_term();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
